// File: rtl/tgl_hs_rx_pkg.sv
// Shared definitions for the toggle-handshake receiver: defaults and FSM encoding.
package tgl_hs_rx_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

endpackage : tgl_hs_rx_pkg

// File: rtl/tgl_hs_rx_if.sv
// Toggle-request sender side plus valid/ready consumer side of the receiver.
interface tgl_hs_rx_if
    import tgl_hs_rx_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              req_tgl;
    logic [DATA_W-1:0] din;
    logic              ack_tgl;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              overrun;

    // Environment side: sender and consumer
    modport master (
        output req_tgl, din, dout_ready,
        input  ack_tgl, dout, dout_valid, overrun
    );

    // Receiver side
    modport slave (
        input  req_tgl, din, dout_ready,
        output ack_tgl, dout, dout_valid, overrun
    );
endinterface : tgl_hs_rx_if

// File: rtl/tgl_sync.sv
// Multi-flop synchroniser for the asynchronous request toggle.
module tgl_sync
    import tgl_hs_rx_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic req_sync
);
    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the raw toggle in at the bottom of the chain
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], async_in};
    end

    // Chain register, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain_q <= '0;
        else      chain_q <= chain_d;
    end

    assign req_sync = chain_q[STAGES-1];
endmodule : tgl_sync

// File: rtl/tgl_hs_rx.sv
// Receiver for a two-phase toggle handshake: one captured word per request flip,
// presented on a valid/ready stream, acknowledged by toggling ack_tgl once consumed.
module tgl_hs_rx
    import tgl_hs_rx_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    tgl_hs_rx_if.slave  bus
);
    logic              req_sync;
    logic              evt_c;

    state_e            state_q,      state_d;
    logic              req_seen_q,   req_seen_d;
    logic [DATA_W-1:0] dout_q,       dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              ack_q,        ack_d;
    logic              overrun_q,    overrun_d;

    tgl_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.req_tgl),
        .req_sync (req_sync)
    );

    assign evt_c = (req_sync != req_seen_q);

    // Next-state and register updates; a pending toggle outside IDLE is left unseen
    always_comb begin
        state_d      = state_q;
        req_seen_d   = req_seen_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        ack_d        = ack_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            ST_IDLE: begin
                if (evt_c) begin
                    dout_d       = bus.din;
                    req_seen_d   = req_sync;
                    dout_valid_d = 1'b1;
                    state_d      = ST_VALID;
                end
            end
            ST_VALID: begin
                if (evt_c) overrun_d = 1'b1;
                if (dout_valid_q && bus.dout_ready) begin
                    dout_valid_d = 1'b0;
                    state_d      = ST_ACK;
                end
            end
            ST_ACK: begin
                if (evt_c) overrun_d = 1'b1;
                ack_d   = ~ack_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            req_seen_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_seen_q   <= req_seen_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ack_q        <= ack_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.ack_tgl    = ack_q;
    assign bus.overrun    = overrun_q;
endmodule : tgl_hs_rx

// File: tb/tb_tgl_hs_rx.sv
// Testbench for tgl_hs_rx: toggle sender model, expected-word queue, per-scenario tasks.
module tb_tgl_hs_rx;
    import tgl_hs_rx_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned SS = 2;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_ack;

    tgl_hs_rx_if #(.DATA_W(DW)) bus ();

    tgl_hs_rx #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sender: present a word and flip the request; remember what must come out
    task automatic send(input logic [DW-1:0] d);
        bus.din     = d;
        bus.req_tgl = ~bus.req_tgl;
        exp_q.push_back(d);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.dout_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_ack_change(input logic prev, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ack_tgl !== prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset(input logic req_level);
        rst            = 1'b0;
        bus.req_tgl    = req_level;
        bus.din        = '0;
        bus.dout_ready = 1'b0;
        exp_q.delete();
        exp_ack = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] e;
        bit            ok;
        apply_reset(1'b0);
        checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid); end
        checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        checks++; if (bus.ack_tgl !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.ack_tgl); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
        send(8'hA5);
        wait_valid(ok);
        checks++; if (!ok) begin failures++; $display("FAIL reset_prep_valid got=timeout exp=valid"); end
        e = exp_q.pop_front();
        checks++; if (bus.dout !== e) begin failures++; $display("FAIL reset_prep_dout got=%h exp=%h", bus.dout, e); end
        // Async reset in the middle of a cycle while the word is held
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", bus.dout_valid); end
        checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL async_rst_dout got=%h exp=00", bus.dout); end
        checks++; if (bus.ack_tgl !== 1'b0) begin failures++; $display("FAIL async_rst_ack got=%b exp=0", bus.ack_tgl); end
        checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL async_rst_state got=%0d exp=0", dut.state_q); end
        apply_reset(1'b0);
        repeat (6) tick();
        checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL dropped_word_valid got=%b exp=0", bus.dout_valid); end
        checks++; if (bus.ack_tgl !== 1'b0) begin failures++; $display("FAIL dropped_word_ack got=%b exp=0", bus.ack_tgl); end
    endtask

    task automatic test_single_word();
        logic [DW-1:0] e;
        bus.dout_ready = 1'b1;
        send(8'h3C);
        tick();
        tick();
        checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", bus.dout_valid); end
        tick();
        checks++; if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL single_valid_edge3 got=%b exp=1", bus.dout_valid); end
        e = exp_q.pop_front();
        checks++; if (bus.dout !== e) begin failures++; $display("FAIL single_dout got=%h exp=%h", bus.dout, e); end
        tick();
        checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop got=%b exp=0", bus.dout_valid); end
        checks++; if (bus.ack_tgl !== exp_ack) begin failures++; $display("FAIL single_ack_early got=%b exp=%b", bus.ack_tgl, exp_ack); end
        exp_ack = ~exp_ack;
        tick();
        checks++; if (bus.ack_tgl !== exp_ack) begin failures++; $display("FAIL single_ack_flip got=%b exp=%b", bus.ack_tgl, exp_ack); end
        repeat (4) tick();
        checks++; if (bus.ack_tgl !== exp_ack) begin failures++; $display("FAIL single_ack_once got=%b exp=%b", bus.ack_tgl, exp_ack); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e;
        bit            ok;
        bus.dout_ready = 1'b0;
        send(8'h5A);
        wait_valid(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_valid got=timeout exp=valid"); end
        e = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== e) begin failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", i, bus.dout_valid, bus.dout, e); end
            checks++; if (bus.ack_tgl !== exp_ack) begin failures++; $display("FAIL bp_ack_hold cyc=%0d got=%b exp=%b", i, bus.ack_tgl, exp_ack); end
            tick();
        end
        bus.dout_ready = 1'b1;
        tick();
        checks++; if (bus.dout_valid !== 1'b0 || bus.ack_tgl !== exp_ack) begin failures++; $display("FAIL bp_handshake got=%b/%b exp=0/%b", bus.dout_valid, bus.ack_tgl, exp_ack); end
        exp_ack = ~exp_ack;
        tick();
        checks++; if (bus.ack_tgl !== exp_ack) begin failures++; $display("FAIL bp_ack_flip got=%b exp=%b", bus.ack_tgl, exp_ack); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] e;
        logic          prev;
        bit            ok;
        int            flips = 0;
        bus.dout_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            send(DW'(w));
            wait_valid(ok);
            checks++; if (!ok) begin failures++; $display("FAIL stream_valid w=%0d got=timeout exp=valid", w); end
            e = exp_q.pop_front();
            checks++; if (bus.dout !== e) begin failures++; $display("FAIL stream_dout w=%0d got=%h exp=%h", w, bus.dout, e); end
            prev = bus.ack_tgl;
            wait_ack_change(prev, ok);
            if (ok) flips++;
            exp_ack = ~exp_ack;
            checks++; if (bus.ack_tgl !== exp_ack) begin failures++; $display("FAIL stream_ack w=%0d got=%b exp=%b", w, bus.ack_tgl, exp_ack); end
        end
        checks++; if (flips !== 4) begin failures++; $display("FAIL stream_flips got=%0d exp=4", flips); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL stream_overrun got=%b exp=0", bus.overrun); end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] e;
        logic          prev;
        bit            ok;
        int            flips = 0;
        bus.dout_ready = 1'b0;
        send(8'h11);
        wait_valid(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovr_valid1 got=timeout exp=valid"); end
        send(8'h22);
        repeat (SS + 1) tick();
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
        e = exp_q.pop_front();
        checks++; if (bus.dout !== e) begin failures++; $display("FAIL ovr_dout1 got=%h exp=%h", bus.dout, e); end
        bus.dout_ready = 1'b1;
        prev = bus.ack_tgl;
        wait_ack_change(prev, ok);
        if (ok) flips++;
        wait_valid(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovr_valid2 got=timeout exp=valid"); end
        e = exp_q.pop_front();
        checks++; if (bus.dout !== e) begin failures++; $display("FAIL ovr_dout2 got=%h exp=%h", bus.dout, e); end
        prev = bus.ack_tgl;
        wait_ack_change(prev, ok);
        if (ok) flips++;
        repeat (4) tick();
        checks++; if (flips !== 2) begin failures++; $display("FAIL ovr_flips got=%0d exp=2", flips); end
        checks++; if (bus.ack_tgl !== exp_ack) begin failures++; $display("FAIL ovr_ack_parity got=%b exp=%b", bus.ack_tgl, exp_ack); end
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
        checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL ovr_extra_word got=%b exp=0", bus.dout_valid); end
    endtask

    task automatic test_reset_release_high();
        logic [DW-1:0] e;
        rst            = 1'b0;
        bus.req_tgl    = 1'b1;
        bus.din        = 8'h77;
        bus.dout_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'h77);
        exp_ack = 1'b0;
        tick();
        tick();
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL rel_overrun_cleared got=%b exp=0", bus.overrun); end
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL rel_early_valid got=%b exp=0", bus.dout_valid); end
        tick();
        checks++; if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL rel_valid got=%b exp=1", bus.dout_valid); end
        e = exp_q.pop_front();
        checks++; if (bus.dout !== e) begin failures++; $display("FAIL rel_dout got=%h exp=%h", bus.dout, e); end
        tick();
        exp_ack = ~exp_ack;
        tick();
        checks++; if (bus.ack_tgl !== exp_ack) begin failures++; $display("FAIL rel_ack got=%b exp=%b", bus.ack_tgl, exp_ack); end
    endtask

    initial begin
        rst            = 1'b0;
        bus.req_tgl    = 1'b0;
        bus.din        = '0;
        bus.dout_ready = 1'b0;
        exp_ack        = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_stream();
        test_overrun();
        test_reset_release_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule : tb_tgl_hs_rx
